glyph_row_draw: RTL and testbench

Parametrised successor to the note display renderer. Rasterises a row of NUM_GLYPHS monochrome bitmaps, each GLYPH_W×GLYPH_H, into VGA-adapter pixel writes (x_out/y_out/colour/writeEn), one pixel per clock. With CLEAR_PASS_EN defined, it first erases the row drawn by the previous command. It sits between the note/octave glyph selection logic and the VGA adapter, and adds an explicit busy/done handshake.

---
 rtl/glyph_row_draw.sv | 122 ++++++++++++
 tb/tb_glyph_row_draw.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/glyph_row_draw.sv
// glyph_row_draw: rasterises a row of monochrome glyph bitmaps into one VGA pixel write per clock.
// Define CLEAR_PASS_EN to erase the previously drawn row before each draw.
module glyph_row_draw #(
  parameter int NUM_GLYPHS = 3,
  parameter int GLYPH_W = 12,
  parameter int GLYPH_H = 12,
  parameter int GAP = 0,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int COLOUR_W = 3
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  ld,
  input  logic [NUM_GLYPHS*GLYPH_W*GLYPH_H-1:0] glyph_bits,
  input  logic [X_W-1:0]                        x,
  input  logic [Y_W-1:0]                        y,
  input  logic [COLOUR_W-1:0]                   colour_in,
  output logic [X_W-1:0]                        x_out,
  output logic [Y_W-1:0]                        y_out,
  output logic [COLOUR_W-1:0]                   colour,
  output logic                                  writeEn,
  output logic                                  busy,
  output logic                                  done
);
  localparam int P = NUM_GLYPHS * GLYPH_W * GLYPH_H;
  localparam int IW = $clog2(P);
  localparam int CW = $clog2(GLYPH_W + 1);
  localparam int RW = $clog2(GLYPH_H + 1);
  localparam int GW = $clog2(NUM_GLYPHS + 1);
  localparam int PITCH = GLYPH_W + GAP;
  localparam logic [1:0] IDLE = 2'd0, DRAW = 2'd1;
`ifdef CLEAR_PASS_EN
  localparam logic [1:0] CLEAR = 2'd2;
  logic prev_valid;
  logic [X_W-1:0] prev_x;
  logic [Y_W-1:0] prev_y;
`endif
  logic [1:0] state;
  logic [IW-1:0] idx, bi;
  logic [CW-1:0] c;
  logic [RW-1:0] r;
  logic [GW-1:0] g;
  logic [P-1:0] bits_q;
  logic [X_W-1:0] xq, bx;
  logic [Y_W-1:0] yq, by;
  logic [COLOUR_W-1:0] cq;
  logic last, c_last, r_last, clr;
  always_comb begin
    last = idx == IW'(P - 1);
    c_last = c == CW'(GLYPH_W - 1);
    r_last = r == RW'(GLYPH_H - 1);
    bi = IW'(P - 1) - idx;
`ifdef CLEAR_PASS_EN
    clr = state == CLEAR;
    bx = clr ? prev_x : xq;
    by = clr ? prev_y : yq;
`else
    clr = 1'b0;
    bx = xq;
    by = yq;
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      x_out <= '0;
      y_out <= '0;
      colour <= '0;
      writeEn <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      idx <= '0;
      c <= '0;
      r <= '0;
      g <= '0;
`ifdef CLEAR_PASS_EN
      prev_valid <= 1'b0;
      prev_x <= '0;
      prev_y <= '0;
`endif
    end else begin
      done <= 1'b0;
      busy <= ld || state != IDLE;
      if (state == IDLE) begin
        writeEn <= 1'b0;
        colour <= '0;
        if (ld) begin
          bits_q <= glyph_bits;
          xq <= x;
          yq <= y;
          cq <= colour_in;
`ifdef CLEAR_PASS_EN
          state <= prev_valid ? CLEAR : DRAW;
`else
          state <= DRAW;
`endif
        end
      end else begin
        x_out <= bx + X_W'(PITCH * g + c);
        y_out <= by + Y_W'(r);
        writeEn <= clr | bits_q[bi];
        colour <= clr ? '0 : cq;
        // one flat pixel index, mirrored by column/row/glyph counters that wrap together
        idx <= last ? '0 : idx + 1'b1;
        c <= (last || c_last) ? '0 : c + 1'b1;
        r <= (last || (c_last && r_last)) ? '0 : c_last ? r + 1'b1 : r;
        g <= last ? '0 : (c_last && r_last) ? g + 1'b1 : g;
        if (last && clr) state <= DRAW;
        if (last && !clr) begin
          state <= IDLE;
          done <= 1'b1;
`ifdef CLEAR_PASS_EN
          prev_valid <= 1'b1;
          prev_x <= xq;
          prev_y <= yq;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_glyph_row_draw.sv
// tb_glyph_row_draw: pixel-stream model of the row renderer checked every cycle, plus literal pins.
module tb_glyph_row_draw;
  localparam int P = 432;
`ifdef CLEAR_PASS_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif
  typedef struct {
    bit chk;
    int x;
    int y;
    int col;
    bit we;
    bit done;
    bit busy;
  } rec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic ld = 1'b0;
  logic [P-1:0] glyph_bits = '0;
  logic [7:0] x = '0;
  logic [6:0] y = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic writeEn, busy, done;

  logic ld2 = 1'b0;
  logic [15:0] bits2 = 16'hFFFF;
  logic [7:0] x2 = 8'd30;
  logic [6:0] y2 = 7'd7;
  logic [2:0] col2 = 3'd6;
  logic [7:0] x2o;
  logic [6:0] y2o;
  logic [2:0] c2o;
  logic we2, busy2, done2;

  glyph_row_draw dut (
    .clk(clk), .reset(reset), .ld(ld), .glyph_bits(glyph_bits), .x(x), .y(y),
    .colour_in(colour_in), .x_out(x_out), .y_out(y_out), .colour(colour),
    .writeEn(writeEn), .busy(busy), .done(done)
  );

  glyph_row_draw #(.NUM_GLYPHS(2), .GLYPH_W(4), .GLYPH_H(2), .GAP(2)) dut2 (
    .clk(clk), .reset(reset), .ld(ld2), .glyph_bits(bits2), .x(x2), .y(y2),
    .colour_in(col2), .x_out(x2o), .y_out(y2o), .colour(c2o),
    .writeEn(we2), .busy(busy2), .done(done2)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  int cyc = 0, done_at = -1, n_we = 0, n_c0 = 0;
  bit armed = 1'b0;
  rec_t q[$];
  int wx[$];
  bit m_pv = 1'b0;
  int m_px = 0, m_py = 0;

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // expected per-cycle outputs of one accepted command, derived from scan order and placement rules
  task automatic push_cmd(input logic [P-1:0] b, input int x0, input int y0, input int col);
    rec_t e;
    int n, tot, lc, bx, by;
    lc = (CLR && m_pv) ? P : 0;
    tot = lc + P;
    n = 0;
    e = '{0, 0, 0, 0, 0, 0, 1};
    q.push_back(e);
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 1 || lc != 0) begin
        bx = pass == 0 ? m_px : x0;
        by = pass == 0 ? m_py : y0;
        for (int k = 0; k < 3; k++)
          for (int r = 0; r < 12; r++)
            for (int c = 0; c < 12; c++) begin
              e.chk = 1;
              e.x = (bx + k * 12 + c) % 256;
              e.y = (by + r) % 128;
              e.col = pass == 0 ? 0 : col;
              e.we = pass == 0 ? 1'b1 : b[P - 1 - (k * 144 + r * 12 + c)];
              e.done = n == tot - 1;
              e.busy = 1;
              q.push_back(e);
              n++;
            end
      end
    end
    m_pv = 1'b1;
    m_px = x0;
    m_py = y0;
  endtask

  always @(posedge clk) begin
    rec_t e;
    #1;
    cyc++;
    if (done) done_at = cyc;
    if (writeEn) begin
      n_we++;
      if (colour == 3'd0) n_c0++;
      else wx.push_back(int'(x_out));
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      check("writeEn", int'(writeEn), int'(e.we));
      check("done", int'(done), int'(e.done));
      check("busy", int'(busy), int'(e.busy));
      check("colour", int'(colour), e.chk ? e.col : 0);
      if (e.chk) begin
        check("x_out", int'(x_out), e.x);
        check("y_out", int'(y_out), e.y);
      end
    end else if (armed) begin
      check("idle_we", int'(writeEn), 0);
      check("idle_busy", int'(busy), 0);
      check("idle_done", int'(done), 0);
      check("idle_colour", int'(colour), 0);
    end
  end

  task automatic cmd(input logic [P-1:0] b, input int x0, input int y0, input int col);
    @(negedge clk);
    glyph_bits = b;
    x = 8'(x0);
    y = 7'(y0);
    colour_in = 3'(col);
    ld = 1'b1;
    push_cmd(b, x0, y0, col);
    cyc = -1;
    done_at = -1;
    n_we = 0;
    n_c0 = 0;
    wx.delete();
    @(negedge clk);
    ld = 1'b0;
    glyph_bits = ~b;
    x = 8'(x0 + 77);
    y = 7'(y0 + 3);
    colour_in = ~3'(col);
  endtask

  task automatic wait_idle(input string nm);
    for (int i = 0; i < 3000 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      check({nm, "_timeout"}, q.size(), 0);
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int mn, mx, cnt, dn;
    repeat (2) @(negedge clk);
    check("rst_x", int'(x_out), 0);
    check("rst_y", int'(y_out), 0);
    check("rst_colour", int'(colour), 0);
    check("rst_we", int'(writeEn), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    reset = 1'b0;
    armed = 1'b1;
    // glyph 0 solid, others blank
    cmd({{144{1'b1}}, 288'b0}, 10, 20, 5);
    wait_idle("a");
    check("a_writes", n_we, 144);
    check("a_done_cycle", done_at, 432);
    mn = 999;
    mx = -1;
    foreach (wx[i]) begin
      if (wx[i] < mn) mn = wx[i];
      if (wx[i] > mx) mx = wx[i];
    end
    check("a_xmin", mn, 10);
    check("a_xmax", mx, 21);
    cmd({27{16'hA5C3}}, 0, 0, 3);
    wait_idle("b");
    cmd({54{8'h3C}}, 40, 50, 3);
    wait_idle("c");
    check("c_clear_pixels", n_c0, CLR ? 432 : 0);
    check("c_done_cycle", done_at, CLR ? 864 : 432);
    cmd({12'hFFF, 420'b0}, 250, 5, 7);
    wait_idle("wrap");
    check("wrap_count", wx.size(), 12);
    for (int j = 0; j < 12 && j < wx.size(); j++) check("wrap_x", wx[j], j < 6 ? 250 + j : j - 6);
    // ld while busy must be ignored
    cmd({108{4'h9}}, 60, 30, 6);
    for (int i = 0; i < 100 && cyc < 50; i++) @(negedge clk);
    ld = 1'b1;
    x = 8'd99;
    colour_in = 3'd2;
    @(negedge clk);
    ld = 1'b0;
    wait_idle("d");
    check("d_draw_writes", wx.size(), 216);
    check("d_done_cycle", done_at, CLR ? 864 : 432);
    // reset during pixel 100 of the draw pass
    cmd({432{1'b1}}, 100, 60, 4);
    for (int i = 0; i < 2000 && cyc < (CLR ? 432 : 0) + 101; i++) @(negedge clk);
    reset = 1'b1;
    q.delete();
    q.push_back('{1, 0, 0, 0, 0, 0, 0});
    m_pv = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("e_aborted_busy", int'(busy), 0);
    cmd({48{9'h1A5}}, 5, 9, 1);
    wait_idle("f");
    check("f_done_cycle", done_at, 432);
    check("f_clear_pixels", n_c0, 0);
    // narrow instance with a gap between glyphs
    @(negedge clk);
    ld2 = 1'b1;
    @(negedge clk);
    ld2 = 1'b0;
    cnt = 0;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      if (we2) begin
        check("g2_x", int'(x2o), 30 + (cnt / 8) * 6 + cnt % 4);
        check("g2_y", int'(y2o), 7 + (cnt / 4) % 2);
        check("g2_colour", int'(c2o), 6);
        cnt++;
      end
      if (done2) dn++;
    end
    check("g2_writes", cnt, 16);
    check("g2_done_pulses", dn, 1);
    check("g2_busy_end", int'(busy2), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
